imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Writer side of the core's instruction memory. Receives a framed little-endian byte stream from a host-side byte source (UART receiver or testbench).
- Assembles 32-bit instruction words and drives a synchronous write port into the instruction memory.
- Holds the core in reset (core_reset) until a complete, checksum-verified program has been written.

Parameters:
- BASE_ADDR, 32'h0000_0000: byte address of the first written word.
- MAX_WORDS, 256: largest accepted word count (instruction memory depth).
- TIMEOUT, 1000000: idle cycles allowed between bytes inside a frame; must be >= 2.
- SYNC_BYTE, 8'hA5: frame start marker.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- rx_valid  input  1  rx_data valid this cycle.
- rx_data  input  8  received byte.
- rx_ready  output  1  loader accepts a byte; a byte transfers when rx_valid && rx_ready.
- imem_we  output  1  instruction-memory write strobe, one cycle per word.
- imem_addr  output  32  byte address of the write, word aligned.
- imem_wdata  output  32  instruction word.
- core_reset  output  1  drives the core's reset; high until load succeeds.
- busy  output  1  frame in progress (COUNT, DATA, CSUM).
- done  output  1  load succeeded (sticky).
- err  output  1  load failed (sticky).

Behaviour:
- Reset values: rx_ready=1, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, core_reset=1, busy=0, done=0, err=0, all counters and the checksum at 0, state=IDLE.
- Reset asserted mid-frame: return to IDLE next edge; no further write is issued for a partially assembled word.
- States: IDLE, COUNT, DATA, CSUM, DONE, ERR.
- IDLE: discard accepted bytes that are not SYNC_BYTE. On SYNC_BYTE go to COUNT; clear the checksum, byte index and timeout counter.
- COUNT: accept 4 bytes as a little-endian word_count; the first byte is bits [7:0].
  - After the 4th byte, word_count==0 or word_count>MAX_WORDS -> ERR.
  - Otherwise -> DATA.
- DATA: accept bytes little-endian into a 32-bit shift/assemble register.
  - When the 4th byte of word k is accepted on cycle N: imem_we=1 on cycle N+1 only, with imem_addr=BASE_ADDR+4*k and imem_wdata=the assembled word.
  - k wraps nowhere; it is bounded by word_count.
  - After word word_count-1 -> CSUM.
- CSUM: accept one byte.
  - Equal to the running XOR of all accepted bytes after SYNC_BYTE (count bytes and data bytes) -> DONE.
  - Otherwise -> ERR.
- DONE: done=1, core_reset=0, rx_ready=0. Remain until reset.
- ERR: err=1, core_reset=1, rx_ready=0. Remain until reset. Words already written are not undone.
- core_reset=1 in every state except DONE. It falls on the cycle DONE is entered (registered output, one cycle after the checksum byte is accepted).
- busy=1 exactly in COUNT, DATA and CSUM.
- Timeout:
  - Counter runs in COUNT, DATA and CSUM, incrementing each cycle without a transfer.
  - Cleared on every accepted byte.
  - Reaching TIMEOUT -> ERR.
  - No timeout in IDLE.
- Same-cycle events: a byte transfer and the timeout terminal count in the same cycle -> the byte wins and the counter clears.
- rx_ready is combinational from state only. No back-pressure is needed because the loader accepts one byte per cycle.

Test Plan:
- Nominal load: bytes A5, 02 00 00 00, 93 00 50 00, 13 01 10 00, C3 -> two writes: addr 0x0 data 0x00500093, then addr 0x4 data 0x00100113, each imem_we pulse one cycle wide. done=1, core_reset=0 one cycle after C3; err=0.
- Garbage before sync: 00 FF 5A then the nominal frame -> identical writes and done. Garbage bytes cause no state change.
- Bad checksum: nominal frame with last byte C2 -> both writes occur, then err=1, core_reset stays 1, done=0, rx_ready=0.
- Illegal count: A5 00 00 00 00 -> err=1 after 4th count byte, no imem_we. A5 01 01 00 00 (257 > MAX_WORDS) -> err=1.
- Timeout with TIMEOUT=16: A5 02 00 00 00 93 00, then rx_valid low for 16 cycles -> err=1 on the 16th idle cycle, no write issued. Same stall of 15 cycles followed by a byte -> no error.
- Reset mid-frame: assert reset after 6 data bytes of the nominal frame -> next cycle state IDLE, all outputs at reset values, no write. Resend the full frame -> done, with exactly two writes.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: writer side of the instruction memory.
// Receives a framed little-endian byte stream
//   SYNC_BYTE, word_count[4 bytes], words[4*word_count bytes], xor checksum
// assembles 32-bit words and writes them into the instruction memory.
// The core is held in reset until a full, checksum-verified program is loaded.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   rx_valid/rx_data      incoming byte stream
//   rx_ready              loader accepts a byte (depends on state only)
//   imem_we/addr/wdata    instruction-memory write port, one-cycle strobe
//   core_reset            high until the load succeeds
//   busy                  frame in progress (COUNT, DATA, CSUM)
//   done / err            sticky load success / failure
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 256,
  parameter int unsigned TIMEOUT   = 1000000,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        core_reset,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    COUNT,
    DATA,
    CSUM,
    DONE,
    ERR
  } state_t;

  state_t         state_q, state_d;
  logic [1:0]     bidx_q, bidx_d;
  logic [31:0]    wcnt_q, wcnt_d;
  logic [31:0]    widx_q, widx_d;
  logic [31:0]    sh_q, sh_d;
  logic [7:0]     csum_q, csum_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic           we_q, we_d;
  logic [31:0]    addr_q, addr_d;
  logic [31:0]    wdata_q, wdata_d;
  logic           xfer;

  assign rx_ready   = (state_q != DONE) && (state_q != ERR);
  assign busy       = (state_q == COUNT) || (state_q == DATA) || (state_q == CSUM);
  assign done       = (state_q == DONE);
  assign err        = (state_q == ERR);
  assign core_reset = (state_q != DONE);
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign xfer       = rx_valid && rx_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      bidx_q  <= '0;
      wcnt_q  <= '0;
      widx_q  <= '0;
      sh_q    <= '0;
      csum_q  <= '0;
      tmo_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= BASE_ADDR;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      bidx_q  <= bidx_d;
      wcnt_q  <= wcnt_d;
      widx_q  <= widx_d;
      sh_q    <= sh_d;
      csum_q  <= csum_d;
      tmo_q   <= tmo_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bidx_d  = bidx_q;
    wcnt_d  = wcnt_q;
    widx_d  = widx_q;
    sh_d    = sh_q;
    csum_d  = csum_q;
    tmo_d   = tmo_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;

    // Idle-cycle watchdog inside a frame; an accepted byte always clears it,
    // so a byte arriving on the terminal-count cycle wins.
    if (busy) begin
      if (xfer) begin
        tmo_d = '0;
      end else if (tmo_q == TW'(TIMEOUT - 1)) begin
        state_d = ERR;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (xfer && (rx_data == SYNC_BYTE)) begin
          state_d = COUNT;
          csum_d  = '0;
          bidx_d  = '0;
          tmo_d   = '0;
          widx_d  = '0;
        end
      end
      COUNT: begin
        if (xfer) begin
          csum_d = csum_q ^ rx_data;
          wcnt_d = {rx_data, wcnt_q[31:8]};
          bidx_d = bidx_q + 2'd1;
          if (bidx_q == 2'd3) begin
            if ((wcnt_d == '0) || (wcnt_d > MAX_WORDS)) state_d = ERR;
            else                                        state_d = DATA;
          end
        end
      end
      DATA: begin
        if (xfer) begin
          csum_d = csum_q ^ rx_data;
          sh_d   = {rx_data, sh_q[31:8]};
          bidx_d = bidx_q + 2'd1;
          if (bidx_q == 2'd3) begin
            we_d    = 1'b1;
            addr_d  = BASE_ADDR + (widx_q << 2);
            wdata_d = sh_d;
            widx_d  = widx_q + 32'd1;
            if (widx_q == wcnt_q - 32'd1) state_d = CSUM;
          end
        end
      end
      CSUM: begin
        if (xfer) begin
          state_d = (rx_data == csum_q) ? DONE : ERR;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: expected memory writes are queued when
// a frame is driven and popped by a write monitor when imem_we is seen.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        core_reset;
  logic        busy;
  logic        done;
  logic        err;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;
  int unsigned n_writes = 0;
  logic [63:0] exp_q[$];
  logic        prev_we = 1'b0;

  always #5 clk = ~clk;

  imem_loader #(
    .BASE_ADDR (32'h0000_0000),
    .MAX_WORDS (256),
    .TIMEOUT   (16),
    .SYNC_BYTE (8'hA5)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_reset (core_reset),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Write monitor: pops the scoreboard on every strobe, and checks the
  // strobe is never two cycles wide.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      n_writes++;
      chk("we_width", 64'(prev_we), 64'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_we", 64'd1, 64'd0);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        chk("waddr", 64'(imem_addr), 64'(e[63:32]));
        chk("wdata", 64'(imem_wdata), 64'(e[31:0]));
      end
    end
    prev_we = imem_we;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_list(input logic [7:0] q[$]);
    foreach (q[i]) send(q[i]);
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rx_ready"}, 64'(rx_ready), 64'd1);
    chk({tag, "_we"}, 64'(imem_we), 64'd0);
    chk({tag, "_addr"}, 64'(imem_addr), 64'd0);
    chk({tag, "_wdata"}, 64'(imem_wdata), 64'd0);
    chk({tag, "_core_reset"}, 64'(core_reset), 64'd1);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_err"}, 64'(err), 64'd0);
  endtask

  task automatic chk_end(input string tag, input logic exp_done);
    chk({tag, "_pending"}, 64'(exp_q.size()), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'(exp_done));
    chk({tag, "_err"}, 64'(err), 64'(!exp_done));
    chk({tag, "_core_reset"}, 64'(core_reset), 64'(!exp_done));
    chk({tag, "_rx_ready"}, 64'(rx_ready), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  task automatic push_nominal();
    exp_q.push_back({32'h0000_0000, 32'h0050_0093});
    exp_q.push_back({32'h0000_0004, 32'h0010_0113});
  endtask

  // Builds a frame of n random words; checksum and expected writes computed here.
  task automatic random_frame(input int unsigned n, input logic bad_csum);
    logic [7:0]  q[$];
    logic [7:0]  cs;
    logic [31:0] w;
    logic [31:0] nn;
    nn = n;
    cs = 8'h00;
    q.push_back(8'hA5);
    for (int unsigned i = 0; i < 4; i++) begin
      q.push_back(nn[8*i +: 8]);
      cs = cs ^ nn[8*i +: 8];
    end
    for (int unsigned k = 0; k < n; k++) begin
      w = $urandom;
      exp_q.push_back({32'(k * 4), w});
      for (int unsigned i = 0; i < 4; i++) begin
        q.push_back(w[8*i +: 8]);
        cs = cs ^ w[8*i +: 8];
      end
    end
    q.push_back(bad_csum ? ~cs : cs);
    send_list(q);
  endtask

  logic [7:0] nominal[$] = '{8'hA5, 8'h02, 8'h00, 8'h00, 8'h00,
                             8'h93, 8'h00, 8'h50, 8'h00,
                             8'h13, 8'h01, 8'h10, 8'h00};

  initial begin
    int unsigned w0;
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    idle(2);
    reset = 1'b0;
    chk_reset_vals("por");

    // Nominal load
    push_nominal();
    send_list(nominal);
    chk("nom_busy_pre", 64'(busy), 64'd1);
    chk("nom_core_reset_pre", 64'(core_reset), 64'd1);
    send(8'hC3);
    chk_end("nom", 1'b1);
    chk("nom_writes", 64'(n_writes), 64'd2);

    // Garbage before sync
    do_reset();
    send_list('{8'h00, 8'hFF, 8'h5A});
    chk_reset_vals("garbage");
    w0 = n_writes;
    push_nominal();
    send_list(nominal);
    send(8'hC3);
    chk_end("garb", 1'b1);
    chk("garb_writes", 64'(n_writes - w0), 64'd2);

    // Bad checksum
    do_reset();
    push_nominal();
    send_list(nominal);
    send(8'hC2);
    chk_end("badcs", 1'b0);

    // Illegal counts
    do_reset();
    w0 = n_writes;
    send_list('{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00});
    chk_end("cnt0", 1'b0);
    do_reset();
    send_list('{8'hA5, 8'h01, 8'h01, 8'h00, 8'h00});
    chk_end("cnt257", 1'b0);
    chk("cnt_writes", 64'(n_writes - w0), 64'd0);

    // Timeout: 15-cycle stall then byte survives
    do_reset();
    push_nominal();
    send_list('{8'hA5, 8'h02, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00});
    idle(15);
    chk("tmo15_err", 64'(err), 64'd0);
    chk("tmo15_busy", 64'(busy), 64'd1);
    send_list('{8'h50, 8'h00, 8'h13, 8'h01, 8'h10, 8'h00, 8'hC3});
    chk_end("tmo15", 1'b1);

    // Timeout: 16-cycle stall errors, no write
    do_reset();
    w0 = n_writes;
    send_list('{8'hA5, 8'h02, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00});
    idle(15);
    chk("tmo16_pre_err", 64'(err), 64'd0);
    idle(1);
    chk_end("tmo16", 1'b0);
    idle(3);
    chk("tmo16_writes", 64'(n_writes - w0), 64'd0);

    // Reset mid-frame after 6 data bytes: word 0 is written, partial word 1 is not
    do_reset();
    w0 = n_writes;
    exp_q.push_back({32'h0000_0000, 32'h0050_0093});
    send_list('{8'hA5, 8'h02, 8'h00, 8'h00, 8'h00,
                8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01});
    chk("mid_pending", 64'(exp_q.size()), 64'd0);
    do_reset();
    chk_reset_vals("mid");
    idle(3);
    chk("mid_writes", 64'(n_writes - w0), 64'd1);
    w0 = n_writes;
    push_nominal();
    send_list(nominal);
    send(8'hC3);
    chk_end("mid_reload", 1'b1);
    chk("mid_reload_writes", 64'(n_writes - w0), 64'd2);

    // Random payloads, including a full-depth frame
    do_reset();
    random_frame(5, 1'b0);
    chk_end("rnd5", 1'b1);
    do_reset();
    random_frame(1, 1'b1);
    chk_end("rnd1_bad", 1'b0);
    do_reset();
    w0 = n_writes;
    random_frame(256, 1'b0);
    chk_end("rnd256", 1'b1);
    chk("rnd256_writes", 64'(n_writes - w0), 64'd256);
    chk("rnd256_last_addr", 64'(imem_addr), 64'h3FC);

    idle(2);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
